// File: rtl/ob_maxpool_2x2_pkg.sv
// Shared types and defaults for the 2x2 max-pool reader of the multi-lane output buffer.
package ob_maxpool_2x2_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_W_DEF     = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        OUT,
        DONE
    } pool_state_e;

endpackage

// File: rtl/ob_maxpool_2x2_if.sv
// Buffer read bus (4 address/data ports per lane) plus the pooled valid/ready stream.
interface ob_maxpool_2x2_if
    import ob_maxpool_2x2_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int WIDTH      = 4,
    parameter int ADDR_W     = ADDR_W_DEF
);
    logic [WIDTH-1:0][ADDR_W-1:0]     add_1, add_2, add_3, add_4;
    logic [WIDTH-1:0][DATA_WIDTH-1:0] out1, out2, out3, out4;
    logic [WIDTH-1:0][DATA_WIDTH-1:0] pool_out;
    logic [ADDR_W-3:0]                pool_idx;
    logic                             pool_valid;
    logic                             pool_ready;

    modport master (
        output add_1, add_2, add_3, add_4,
        input  out1, out2, out3, out4,
        output pool_out, pool_idx, pool_valid,
        input  pool_ready
    );

    modport slave (
        input  add_1, add_2, add_3, add_4,
        output out1, out2, out3, out4,
        input  pool_out, pool_idx, pool_valid,
        output pool_ready
    );
endinterface

// File: rtl/ob_maxpool_2x2_pool_max4.sv
// Combinational max of four buffer words, signed or unsigned compare.
module pool_max4
    import ob_maxpool_2x2_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter bit SIGNED     = 1'b0
) (
    input  logic [DATA_WIDTH-1:0] d0,
    input  logic [DATA_WIDTH-1:0] d1,
    input  logic [DATA_WIDTH-1:0] d2,
    input  logic [DATA_WIDTH-1:0] d3,
    output logic [DATA_WIDTH-1:0] win_max
);
    // Ties return either operand; they carry the same value, so order is irrelevant.
    function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH-1:0] sa;
        logic signed [DATA_WIDTH-1:0] sb;
        sa = a;
        sb = b;
        if (SIGNED) return (sa > sb) ? a : b;
        return (a > b) ? a : b;
    endfunction

    logic [DATA_WIDTH-1:0] m01, m23;

    assign m01     = max2(d0, d1);
    assign m23     = max2(d2, d3);
    assign win_max = max2(m01, m23);

endmodule

// File: rtl/ob_maxpool_2x2.sv
// Walks a ROWS x COLS row-major map in the output buffer one 2x2 window at a time
// (RD -> CAP -> OUT) and emits the per-lane max on a valid/ready port.
module ob_maxpool_2x2
    import ob_maxpool_2x2_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int WIDTH      = 4,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int ROWS       = 4,
    parameter int COLS       = 8,
    parameter bit SIGNED     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    ob_maxpool_2x2_if.master bus
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int HALF_R = ROWS / 2;
    localparam int HALF_C = COLS / 2;

    localparam logic [IDX_W-1:0]  R_LAST   = IDX_W'(HALF_R - 1);
    localparam logic [IDX_W-1:0]  C_LAST   = IDX_W'(HALF_C - 1);
    localparam logic [IDX_W-1:0]  IDX_ROW  = IDX_W'(HALF_C);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * COLS);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(COLS);

    if (ROWS * COLS > 2 ** ADDR_W) begin : g_map_too_big
        $error("ob_maxpool_2x2: ROWS*COLS exceeds buffer depth 2**ADDR_W");
    end
    if ((ROWS % 2 != 0) || (COLS % 2 != 0) || (ROWS < 2) || (COLS < 2)) begin : g_map_odd
        $error("ob_maxpool_2x2: ROWS and COLS must be even and non-zero");
    end

    pool_state_e state, state_nxt;

    logic [IDX_W-1:0]                 r, c;
    logic                             addr_en;
    logic                             pool_valid;
    logic                             hs;
    logic                             last_win;
    logic [ADDR_W-1:0]                a1, a2, a3, a4;
    logic [WIDTH-1:0][DATA_WIDTH-1:0] win_max;
    logic [WIDTH-1:0][DATA_WIDTH-1:0] pool_out_q;
    logic [IDX_W-1:0]                 pool_idx_q;

    assign hs       = pool_valid & bus.pool_ready;
    assign last_win = (r == R_LAST) && (c == C_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        addr_en    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        pool_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RD;
            end
            RD: begin
                busy      = 1'b1;
                addr_en   = 1'b1;
                state_nxt = CAP;
            end
            CAP: begin
                busy      = 1'b1;
                addr_en   = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                busy       = 1'b1;
                addr_en    = 1'b1;
                pool_valid = 1'b1;
                if (bus.pool_ready) state_nxt = last_win ? DONE : RD;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Window counters: column first, row advances when the column wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
            c <= '0;
        end else if (state == DONE) begin
            r <= '0;
            c <= '0;
        end else if (hs) begin
            if (c == C_LAST) begin
                c <= '0;
                r <= (r == R_LAST) ? '0 : r + IDX_W'(1);
            end else begin
                c <= c + IDX_W'(1);
            end
        end
    end

    assign a1 = ADDR_W'(r) * ROW_STEP + (ADDR_W'(c) << 1);
    assign a2 = a1 + ADDR_W'(1);
    assign a3 = a1 + COL_STEP;
    assign a4 = a1 + COL_STEP + ADDR_W'(1);

    for (genvar l = 0; l < WIDTH; l++) begin : g_lane
        assign bus.add_1[l] = addr_en ? a1 : '0;
        assign bus.add_2[l] = addr_en ? a2 : '0;
        assign bus.add_3[l] = addr_en ? a3 : '0;
        assign bus.add_4[l] = addr_en ? a4 : '0;

        pool_max4 #(
            .DATA_WIDTH (DATA_WIDTH),
            .SIGNED     (SIGNED)
        ) u_max (
            .d0      (bus.out1[l]),
            .d1      (bus.out2[l]),
            .d2      (bus.out3[l]),
            .d3      (bus.out4[l]),
            .win_max (win_max[l])
        );
    end

    // Capture stage: buffer data returned for the addresses issued in RD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pool_out_q <= '0;
            pool_idx_q <= '0;
        end else if (state == CAP) begin
            pool_out_q <= win_max;
            pool_idx_q <= r * IDX_ROW + c;
        end
    end

    assign bus.pool_out   = pool_out_q;
    assign bus.pool_idx   = pool_idx_q;
    assign bus.pool_valid = pool_valid;

endmodule

// File: tb/tb_ob_maxpool_2x2.sv
// Directed bench for ob_maxpool_2x2: an unsigned and a signed instance share one buffer model.
module tb_ob_maxpool_2x2;

    localparam int DW = 8;
    localparam int NL = 4;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic pool_ready;
    logic busy_u, done_u, busy_s, done_s;

    int n_cmp  = 0;
    int n_fail = 0;

    int ramp_max [8] = '{9, 11, 13, 15, 25, 27, 29, 31};
    int ramp_a1  [8] = '{0, 2, 4, 6, 16, 18, 20, 22};

    logic [DW-1:0] mem [NL][32];

    ob_maxpool_2x2_if #(.DATA_WIDTH(DW), .WIDTH(NL), .ADDR_W(AW)) bu ();
    ob_maxpool_2x2_if #(.DATA_WIDTH(DW), .WIDTH(NL), .ADDR_W(AW)) bs ();

    assign bu.pool_ready = pool_ready;
    assign bs.pool_ready = pool_ready;

    ob_maxpool_2x2 #(
        .DATA_WIDTH(DW), .WIDTH(NL), .ADDR_W(AW), .ROWS(4), .COLS(8), .SIGNED(1'b0)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy_u),
        .done  (done_u),
        .bus   (bu.master)
    );

    ob_maxpool_2x2 #(
        .DATA_WIDTH(DW), .WIDTH(NL), .ADDR_W(AW), .ROWS(4), .COLS(8), .SIGNED(1'b1)
    ) u_dut_s (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy_s),
        .done  (done_s),
        .bus   (bs.master)
    );

    always #5 clk = ~clk;

    // Buffer model: read data one cycle after the address.
    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            bu.out1[l] <= mem[l][bu.add_1[l]];
            bu.out2[l] <= mem[l][bu.add_2[l]];
            bu.out3[l] <= mem[l][bu.add_3[l]];
            bu.out4[l] <= mem[l][bu.add_4[l]];
            bs.out1[l] <= mem[l][bs.add_1[l]];
            bs.out2[l] <= mem[l][bs.add_2[l]];
            bs.out3[l] <= mem[l][bs.add_3[l]];
            bs.out4[l] <= mem[l][bs.add_4[l]];
        end
    end

    task automatic load_map(input int lane_step);
        for (int l = 0; l < NL; l++)
            for (int a = 0; a < 32; a++)
                mem[l][a] = DW'(a + lane_step * l);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bu.pool_valid === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_u === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_done: done never seen, required within 100 cycles", tag);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({busy_u, done_u, bu.pool_valid, busy_s, done_s, bs.pool_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {busy_u, done_u, bu.pool_valid, busy_s, done_s, bs.pool_valid});
        end
        n_cmp++;
        if ({bu.add_1, bu.add_2, bu.add_3, bu.add_4} !== 80'b0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h required 0", {bu.add_1, bu.add_2, bu.add_3, bu.add_4});
        end
        n_cmp++;
        if ({bu.pool_out, bu.pool_idx} !== 35'b0) begin
            n_fail++;
            $display("FAIL reset_out: got %h required 0", {bu.pool_out, bu.pool_idx});
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_ramp();
        int cyc;
        load_map(0);
        pool_ready = 1'b1;
        pulse_start();
        n_cmp++;
        if (busy_u !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_busy: got %b required 1", busy_u);
        end
        for (int w = 0; w < 8; w++) begin
            wait_valid(cyc);
            n_cmp++;
            // start driven 3 cycles before the first valid; 3 cycles per window afterwards
            if (cyc !== ((w == 0) ? 2 : 3)) begin
                n_fail++;
                $display("FAIL ramp_gap%0d: got %0d cycles required %0d", w, cyc, (w == 0) ? 2 : 3);
                return;
            end
            n_cmp++;
            if ({bu.pool_idx, bu.pool_out} !== {3'(w), {4{8'(ramp_max[w])}}}) begin
                n_fail++;
                $display("FAIL ramp_win%0d: got idx %0d out %h required idx %0d out %h",
                         w, bu.pool_idx, bu.pool_out, w, {4{8'(ramp_max[w])}});
            end
            n_cmp++;
            if ({bu.add_1[0], bu.add_4[3]} !== {5'(ramp_a1[w]), 5'(ramp_a1[w] + 9)}) begin
                n_fail++;
                $display("FAIL ramp_addr%0d: got a1 %0d a4 %0d required a1 %0d a4 %0d",
                         w, bu.add_1[0], bu.add_4[3], ramp_a1[w], ramp_a1[w] + 9);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({done_u, bu.pool_valid, busy_u} !== 3'b100) begin
            n_fail++;
            $display("FAIL ramp_done: got done/valid/busy %b required 100", {done_u, bu.pool_valid, busy_u});
        end
        @(negedge clk);
        n_cmp++;
        if (done_u !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_done_pulse: got %b required 0", done_u);
        end
    endtask

    task automatic test_signed();
        int cyc;
        load_map(0);
        mem[0][0] = 8'h80;
        mem[0][1] = 8'h01;
        mem[0][8] = 8'h7F;
        mem[0][9] = 8'h02;
        pool_ready = 1'b1;
        pulse_start();
        wait_valid(cyc);
        n_cmp++;
        if (bu.pool_out[0] !== 8'h80) begin
            n_fail++;
            $display("FAIL unsigned_max: got %h required 80", bu.pool_out[0]);
        end
        n_cmp++;
        if (bs.pool_out[0] !== 8'h7F) begin
            n_fail++;
            $display("FAIL signed_max: got %h required 7f", bs.pool_out[0]);
        end
        n_cmp++;
        if (bs.pool_out[1] !== 8'd9) begin
            n_fail++;
            $display("FAIL signed_lane1: got %0d required 9", bs.pool_out[1]);
        end
        wait_done("signed");
    endtask

    task automatic test_backpressure();
        int cyc;
        load_map(0);
        pool_ready = 1'b1;
        pulse_start();
        for (int w = 0; w < 3; w++) wait_valid(cyc);
        pool_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bu.pool_valid, bu.pool_idx, bu.pool_out, bu.add_1, bu.add_2, bu.add_3, bu.add_4} !==
                {1'b1, 3'd2, {4{8'd13}}, {4{5'd4}}, {4{5'd5}}, {4{5'd12}}, {4{5'd13}}}) begin
                n_fail++;
                $display("FAIL stall%0d: got v %b idx %0d out %h a %h %h %h %h required v 1 idx 2 out 0d0d0d0d a 4/5/12/13",
                         i, bu.pool_valid, bu.pool_idx, bu.pool_out, bu.add_1, bu.add_2, bu.add_3, bu.add_4);
            end
        end
        pool_ready = 1'b1;
        wait_valid(cyc);
        n_cmp++;
        if ({cyc[3:0], bu.pool_idx, bu.pool_out} !== {4'd3, 3'd3, {4{8'd15}}}) begin
            n_fail++;
            $display("FAIL release: got cyc %0d idx %0d out %h required cyc 3 idx 3 out 0f0f0f0f",
                     cyc, bu.pool_idx, bu.pool_out);
        end
        wait_done("backpressure");
    endtask

    task automatic test_lanes();
        int cyc;
        load_map(32);
        pool_ready = 1'b1;
        pulse_start();
        wait_valid(cyc);
        n_cmp++;
        if (bu.pool_out !== {8'd105, 8'd73, 8'd41, 8'd9}) begin
            n_fail++;
            $display("FAIL lanes_win0: got %h required 69492909", bu.pool_out);
        end
        wait_valid(cyc);
        n_cmp++;
        if (bu.pool_out !== {8'd107, 8'd75, 8'd43, 8'd11}) begin
            n_fail++;
            $display("FAIL lanes_win1: got %h required 6b4b2b0b", bu.pool_out);
        end
        wait_done("lanes");
    endtask

    task automatic test_control();
        int cyc;
        load_map(0);
        pool_ready = 1'b1;
        pulse_start();
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int w = 0; w < 8; w++) begin
            wait_valid(cyc);
            n_cmp++;
            if (cyc < 0 || {bu.pool_idx, bu.pool_out} !== {3'(w), {4{8'(ramp_max[w])}}}) begin
                n_fail++;
                $display("FAIL ignore_start%0d: got cyc %0d idx %0d out %h required idx %0d out %h",
                         w, cyc, bu.pool_idx, bu.pool_out, w, {4{8'(ramp_max[w])}});
                start = 1'b0;
                return;
            end
            start = (w == 4);
        end
        @(negedge clk);
        n_cmp++;
        if (done_u !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_start_done: got %b required 1", done_u);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy_u, bu.pool_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL idle_after%0d: got busy/valid %b required 00", i, {busy_u, bu.pool_valid});
            end
        end

        pulse_start();
        for (int w = 0; w < 4; w++) wait_valid(cyc);
        n_cmp++;
        if (bu.pool_idx !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_rst_idx: got %0d required 3", bu.pool_idx);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy_u, done_u, bu.pool_valid, bu.pool_idx, bu.pool_out,
             bu.add_1, bu.add_2, bu.add_3, bu.add_4} !== 118'b0) begin
            n_fail++;
            $display("FAIL async_rst: got busy %b valid %b idx %0d out %h a1 %h required all 0",
                     busy_u, bu.pool_valid, bu.pool_idx, bu.pool_out, bu.add_1);
        end
        @(negedge clk) rst = 1'b0;
        pulse_start();
        wait_valid(cyc);
        n_cmp++;
        if ({cyc[3:0], bu.pool_idx, bu.pool_out} !== {4'd2, 3'd0, {4{8'd9}}}) begin
            n_fail++;
            $display("FAIL restart: got cyc %0d idx %0d out %h required cyc 2 idx 0 out 09090909",
                     cyc, bu.pool_idx, bu.pool_out);
        end
        wait_done("restart");
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        pool_ready = 1'b0;
        load_map(0);
        repeat (2) @(negedge clk);
        test_reset();
        test_ramp();
        test_signed();
        test_backpressure();
        test_lanes();
        test_control();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
